// File: rtl/preprocessing_multich_top.sv
// Multi-channel preprocessing: timestamps and tags ADC samples, merges channels round-robin into one FWFT FIFO.
// Optional feature macro: PREPROC_THRESHOLD_EN (per-channel strict unsigned threshold gate on queued samples).
`timescale 1ns/1ps

module preprocessing_multich_top #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 16,
  parameter int TS_W    = 64,
  parameter int DEPTH   = 1024,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W   = $clog2(DEPTH) + 1,
  localparam int ENTRY_W = TS_W + CH_W + DATA_W
) (
  input  logic                       clk210_p,
  input  logic                       reset_n_p,
  input  logic                       timekeeper_ready_p,
  input  logic [TS_W-1:0]            timekeeper_time_p,
  input  logic [NUM_CH-1:0]          ch_valid_p,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_p,
  input  logic [NUM_CH-1:0]          ch_enable_p,
  input  logic [NUM_CH*DATA_W-1:0]   ch_threshold_p,
  input  logic                       fifo_rd_en_p,
  output logic [ENTRY_W-1:0]         fifo_dout_p,
  output logic                       fifo_empty_p,
  output logic                       fifo_full_p,
  output logic [CNT_W-1:0]           fifo_count_p,
  output logic [15:0]                drop_count_p,
  output logic [NUM_CH*DATA_W-1:0]   ch_current_data_p
);

  localparam int AW = $clog2(DEPTH);

  logic [NUM_CH-1:0]  qual;
  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  grant_oh;
  logic [NUM_CH-1:0]  drop_vec;
  logic [ENTRY_W-1:0] hold [NUM_CH];
  logic [CH_W-1:0]    rr_ptr;
  logic [CH_W-1:0]    grant_idx;
  logic               grant_any;
  logic               wr_en;
  logic [ENTRY_W-1:0] wr_data;
  logic [4:0]         drop_inc;
  logic [16:0]        drop_sum;
  logic [15:0]        drop_count;
  int unsigned        cand;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   mem_count;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] dout_q;
  logic               dout_valid;
  logic               pop;
  logic               load;
  logic               bypass;

`ifndef PREPROC_THRESHOLD_EN
  logic unused_threshold;
  assign unused_threshold = ^ch_threshold_p;
`endif

  // NOTE: every variable driven from always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    qual = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      qual[i] = ch_valid_p[i] & ch_enable_p[i] & timekeeper_ready_p
`ifdef PREPROC_THRESHOLD_EN
              & (ch_data_p[i*DATA_W +: DATA_W] > ch_threshold_p[i*DATA_W +: DATA_W])
`endif
              ;
    end
  end

  // rr_ptr holds the first channel to search, i.e. one past the last grant.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_CH;
      if (!grant_any && pending[cand]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(cand);
      end
    end
    wr_en    = grant_any && !fifo_full_p;
    grant_oh = '0;
    if (wr_en) grant_oh[grant_idx] = 1'b1;
    wr_data  = hold[grant_idx];
  end

  always_comb begin
    drop_vec = qual & pending & ~grant_oh;
    drop_inc = '0;
    for (int i = 0; i < NUM_CH; i++) drop_inc = drop_inc + 5'(drop_vec[i]);
    drop_sum = {1'b0, drop_count} + 17'(drop_inc);
  end

  // NOTE: sequential state is assigned only with <= so every flop samples pre-edge values.
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      pending           <= '0;
      rr_ptr            <= '0;
      drop_count        <= '0;
      ch_current_data_p <= '0;
      for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid_p[i]) ch_current_data_p[i*DATA_W +: DATA_W] <= ch_data_p[i*DATA_W +: DATA_W];
        // A granted slot is free again this edge, so a new sample may replace it.
        if (qual[i] && (!pending[i] || grant_oh[i])) begin
          hold[i]    <= {timekeeper_time_p, CH_W'(i), ch_data_p[i*DATA_W +: DATA_W]};
          pending[i] <= 1'b1;
        end else if (grant_oh[i]) begin
          pending[i] <= 1'b0;
        end
      end
      if (wr_en) rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign mem_count = wr_ptr - rd_ptr;
  assign pop       = fifo_rd_en_p && dout_valid;
  assign load      = (!dout_valid || pop) && (mem_count != '0);
  // Popping the last entry while writing forwards the write straight to the output stage.
  assign bypass    = pop && (mem_count == '0) && wr_en;

  // NOTE: the storage array has no reset; only pointers and the output stage do, which keeps it RAM-mappable.
  always_ff @(posedge clk210_p) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_q     <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (load || bypass) rd_ptr <= rd_ptr + 1'b1;
      if (load)        dout_q <= mem[rd_ptr[AW-1:0]];
      else if (bypass) dout_q <= wr_data;
      if (load || bypass) dout_valid <= 1'b1;
      else if (pop)       dout_valid <= 1'b0;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fifo_dout_p  = dout_q;
  assign fifo_empty_p = !dout_valid;
  assign fifo_full_p  = (count == CNT_W'(DEPTH));
  assign fifo_count_p = count;
  assign drop_count_p = drop_count;

endmodule

// File: tb/tb_preprocessing_multich_top.sv
// Directed self-checking bench for preprocessing_multich_top (4 channels, 16-entry FIFO).
`timescale 1ns/1ps

module tb_preprocessing_multich_top;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 16;
  localparam int TS_W    = 64;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = 5;
  localparam int ENTRY_W = 82;

  logic                     clk210_p = 1'b0;
  logic                     reset_n_p = 1'b0;
  logic                     timekeeper_ready_p = 1'b1;
  logic [TS_W-1:0]          timekeeper_time_p = '0;
  logic [NUM_CH-1:0]        ch_valid_p = '0;
  logic [NUM_CH*DATA_W-1:0] ch_data_p = '0;
  logic [NUM_CH-1:0]        ch_enable_p = 4'hF;
  logic [NUM_CH*DATA_W-1:0] ch_threshold_p = '0;
  logic                     fifo_rd_en_p = 1'b0;
  logic [ENTRY_W-1:0]       fifo_dout_p;
  logic                     fifo_empty_p;
  logic                     fifo_full_p;
  logic [CNT_W-1:0]         fifo_count_p;
  logic [15:0]              drop_count_p;
  logic [NUM_CH*DATA_W-1:0] ch_current_data_p;

  int checks = 0;
  int errors = 0;

  preprocessing_multich_top #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)
  ) dut (
    .clk210_p(clk210_p), .reset_n_p(reset_n_p),
    .timekeeper_ready_p(timekeeper_ready_p), .timekeeper_time_p(timekeeper_time_p),
    .ch_valid_p(ch_valid_p), .ch_data_p(ch_data_p), .ch_enable_p(ch_enable_p),
    .ch_threshold_p(ch_threshold_p), .fifo_rd_en_p(fifo_rd_en_p),
    .fifo_dout_p(fifo_dout_p), .fifo_empty_p(fifo_empty_p), .fifo_full_p(fifo_full_p),
    .fifo_count_p(fifo_count_p), .drop_count_p(drop_count_p),
    .ch_current_data_p(ch_current_data_p)
  );

  always #2.4 clk210_p = ~clk210_p;

  function automatic logic [ENTRY_W-1:0] ent(input logic [63:0] t, input logic [1:0] c,
                                             input logic [15:0] d);
    return {t, c, d};
  endfunction

  task automatic tick();
    @(posedge clk210_p);
    #1;
  endtask

  task automatic pulse(input int ch, input logic [15:0] d, input logic [63:0] t);
    ch_valid_p = '0;
    ch_valid_p[ch] = 1'b1;
    ch_data_p[ch*DATA_W +: DATA_W] = d;
    timekeeper_time_p = t;
    tick();
    ch_valid_p = '0;
  endtask

  task automatic pulse_mask(input logic [3:0] mask, input logic [15:0] base, input logic [63:0] t);
    for (int i = 0; i < NUM_CH; i++) ch_data_p[i*DATA_W +: DATA_W] = base + 16'(i);
    ch_valid_p = mask;
    timekeeper_time_p = t;
    tick();
    ch_valid_p = '0;
  endtask

  task automatic pop_n(input int n);
    fifo_rd_en_p = 1'b1;
    repeat (n) tick();
    fifo_rd_en_p = 1'b0;
  endtask

  task automatic do_reset();
    ch_valid_p = '0;
    fifo_rd_en_p = 1'b0;
    reset_n_p = 1'b0;
    @(negedge clk210_p);
    @(negedge clk210_p);
    reset_n_p = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n_p = 1'b0;
    #5;
    checks++; if (fifo_empty_p !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", fifo_empty_p); end
    checks++; if (fifo_full_p !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", fifo_full_p); end
    checks++; if (fifo_count_p !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count_p); end
    checks++; if (drop_count_p !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count_p); end
    checks++; if (fifo_dout_p !== '0) begin errors++; $display("FAIL reset_dout got %h exp 0", fifo_dout_p); end
    @(negedge clk210_p);
    reset_n_p = 1'b1;
    tick();
  endtask

  task automatic test_single();
    pulse(0, 16'h1234, 64'd100);
    tick();
    tick();
    checks++; if (fifo_dout_p !== ent(64'd100, 2'd0, 16'h1234)) begin errors++; $display("FAIL t1_dout got %h exp %h", fifo_dout_p, ent(64'd100, 2'd0, 16'h1234)); end
    checks++; if (fifo_count_p !== 5'd1) begin errors++; $display("FAIL t1_count got %0d exp 1", fifo_count_p); end
    checks++; if (fifo_empty_p !== 1'b0) begin errors++; $display("FAIL t1_empty got %b exp 0", fifo_empty_p); end
    pop_n(1);
    checks++; if (fifo_empty_p !== 1'b1) begin errors++; $display("FAIL t1_empty_after_pop got %b exp 1", fifo_empty_p); end
  endtask

  task automatic test_unqualified();
    ch_enable_p = 4'b1011;
    pulse(2, 16'hBEEF, 64'd150);
    ch_enable_p = 4'hF;
    timekeeper_ready_p = 1'b0;
    pulse(3, 16'hCAFE, 64'd151);
    timekeeper_ready_p = 1'b1;
    tick();
    tick();
    checks++; if (fifo_count_p !== 5'd0) begin errors++; $display("FAIL unq_count got %0d exp 0", fifo_count_p); end
    checks++; if (drop_count_p !== 16'd0) begin errors++; $display("FAIL unq_drop got %0d exp 0", drop_count_p); end
    checks++; if (ch_current_data_p[2*DATA_W +: DATA_W] !== 16'hBEEF) begin errors++; $display("FAIL unq_cur2 got %h exp beef", ch_current_data_p[2*DATA_W +: DATA_W]); end
    checks++; if (ch_current_data_p[3*DATA_W +: DATA_W] !== 16'hCAFE) begin errors++; $display("FAIL unq_cur3 got %h exp cafe", ch_current_data_p[3*DATA_W +: DATA_W]); end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [3];
    do_reset();
    pulse_mask(4'hF, 16'd10, 64'd200);
    repeat (4) tick();
    checks++; if (fifo_count_p !== 5'd4) begin errors++; $display("FAIL t2_count got %0d exp 4", fifo_count_p); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (fifo_dout_p !== ent(64'd200, 2'(j), 16'(10 + j))) begin
        errors++; $display("FAIL t2_order%0d got %h exp %h", j, fifo_dout_p, ent(64'd200, 2'(j), 16'(10 + j)));
      end
      pop_n(1);
    end
    // last grant 3, then ch1 alone; next search starts at ch2.
    pulse(1, 16'd21, 64'd300);
    tick();
    tick();
    checks++; if (fifo_dout_p !== ent(64'd300, 2'd1, 16'd21)) begin errors++; $display("FAIL t2_ch1 got %h exp %h", fifo_dout_p, ent(64'd300, 2'd1, 16'd21)); end
    pop_n(1);
    pulse_mask(4'b1101, 16'd30, 64'd400);
    repeat (4) tick();
    order[0] = 2'd2; order[1] = 2'd3; order[2] = 2'd0;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (fifo_dout_p !== ent(64'd400, order[j], 16'd30 + 16'(order[j]))) begin
        errors++; $display("FAIL t2_burst2_%0d got %h exp %h", j, fifo_dout_p, ent(64'd400, order[j], 16'd30 + 16'(order[j])));
      end
      pop_n(1);
    end
  endtask

  task automatic test_empty_and_simul();
    pop_n(5);
    checks++; if (fifo_count_p !== 5'd0) begin errors++; $display("FAIL t4_empty_count got %0d exp 0", fifo_count_p); end
    checks++; if (fifo_empty_p !== 1'b1) begin errors++; $display("FAIL t4_empty got %b exp 1", fifo_empty_p); end
    checks++; if (fifo_dout_p !== ent(64'd400, 2'd0, 16'd30)) begin errors++; $display("FAIL t4_dout_hold got %h exp %h", fifo_dout_p, ent(64'd400, 2'd0, 16'd30)); end
    for (int j = 0; j < 5; j++) begin
      pulse(0, 16'h40 + 16'(j), 64'd500 + 64'(j));
      tick();
    end
    tick();
    checks++; if (fifo_count_p !== 5'd5) begin errors++; $display("FAIL t4_fill got %0d exp 5", fifo_count_p); end
    pulse(0, 16'h50, 64'd600);
    pop_n(1);
    tick();
    checks++; if (fifo_count_p !== 5'd5) begin errors++; $display("FAIL t4_wr_rd_count got %0d exp 5", fifo_count_p); end
    checks++; if (fifo_dout_p !== ent(64'd501, 2'd0, 16'h41)) begin errors++; $display("FAIL t4_wr_rd_head got %h exp %h", fifo_dout_p, ent(64'd501, 2'd0, 16'h41)); end
    pop_n(4);
    checks++; if (fifo_dout_p !== ent(64'd600, 2'd0, 16'h50)) begin errors++; $display("FAIL t4_last_head got %h exp %h", fifo_dout_p, ent(64'd600, 2'd0, 16'h50)); end
    pulse(0, 16'h60, 64'd700);
    pop_n(1);
    checks++; if (fifo_empty_p !== 1'b0) begin errors++; $display("FAIL t4_bypass_empty got %b exp 0", fifo_empty_p); end
    checks++; if (fifo_dout_p !== ent(64'd700, 2'd0, 16'h60)) begin errors++; $display("FAIL t4_bypass_dout got %h exp %h", fifo_dout_p, ent(64'd700, 2'd0, 16'h60)); end
    checks++; if (fifo_count_p !== 5'd1) begin errors++; $display("FAIL t4_bypass_count got %0d exp 1", fifo_count_p); end
    pop_n(1);
    checks++; if (fifo_empty_p !== 1'b1) begin errors++; $display("FAIL t4_drained got %b exp 1", fifo_empty_p); end
  endtask

  task automatic test_threshold();
    do_reset();
    ch_threshold_p[0 +: DATA_W] = 16'h0100;
    pulse(0, 16'h0100, 64'd800);
    pulse(0, 16'h0101, 64'd801);
    tick();
    tick();
`ifdef PREPROC_THRESHOLD_EN
    checks++; if (fifo_count_p !== 5'd1) begin errors++; $display("FAIL t5_count got %0d exp 1", fifo_count_p); end
    checks++; if (fifo_dout_p !== ent(64'd801, 2'd0, 16'h0101)) begin errors++; $display("FAIL t5_dout got %h exp %h", fifo_dout_p, ent(64'd801, 2'd0, 16'h0101)); end
`else
    checks++; if (fifo_count_p !== 5'd2) begin errors++; $display("FAIL t5_count got %0d exp 2", fifo_count_p); end
    checks++; if (fifo_dout_p !== ent(64'd800, 2'd0, 16'h0100)) begin errors++; $display("FAIL t5_dout got %h exp %h", fifo_dout_p, ent(64'd800, 2'd0, 16'h0100)); end
`endif
    checks++; if (drop_count_p !== 16'd0) begin errors++; $display("FAIL t5_drop got %0d exp 0", drop_count_p); end
    checks++; if (ch_current_data_p[0 +: DATA_W] !== 16'h0101) begin errors++; $display("FAIL t5_cur got %h exp 0101", ch_current_data_p[0 +: DATA_W]); end
    ch_threshold_p = '0;
  endtask

  task automatic test_full_overrun();
    do_reset();
    for (int j = 1; j <= DEPTH + 3; j++) begin
      pulse(1, 16'h0100 + 16'(j), 64'(j));
      repeat (3) tick();
    end
    checks++; if (fifo_full_p !== 1'b1) begin errors++; $display("FAIL t3_full got %b exp 1", fifo_full_p); end
    checks++; if (fifo_count_p !== 5'd16) begin errors++; $display("FAIL t3_count got %0d exp 16", fifo_count_p); end
    checks++; if (drop_count_p !== 16'd2) begin errors++; $display("FAIL t3_drop got %0d exp 2", drop_count_p); end
    pop_n(1);
    tick();
    tick();
    checks++; if (fifo_count_p !== 5'd16) begin errors++; $display("FAIL t3_refill got %0d exp 16", fifo_count_p); end
    for (int j = 2; j <= DEPTH + 1; j++) begin
      checks++;
      if (fifo_dout_p !== ent(64'(j), 2'd1, 16'h0100 + 16'(j))) begin
        errors++; $display("FAIL t3_drain%0d got %h exp %h", j, fifo_dout_p, ent(64'(j), 2'd1, 16'h0100 + 16'(j)));
      end
      pop_n(1);
    end
    checks++; if (fifo_empty_p !== 1'b1) begin errors++; $display("FAIL t3_empty got %b exp 1", fifo_empty_p); end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    for (int i = 0; i < NUM_CH; i++) ch_data_p[i*DATA_W +: DATA_W] = 16'h7000 + 16'(i);
    ch_valid_p = 4'hF;
    tick();
    checks++; if (drop_count_p !== 16'd0) begin errors++; $display("FAIL sat_first got %0d exp 0", drop_count_p); end
    tick();
    checks++; if (drop_count_p !== 16'd3) begin errors++; $display("FAIL sat_pop3 got %0d exp 3", drop_count_p); end
    tick();
    checks++; if (drop_count_p !== 16'd6) begin errors++; $display("FAIL sat_pop6 got %0d exp 6", drop_count_p); end
    repeat (16500) tick();
    ch_valid_p = '0;
    checks++; if (drop_count_p !== 16'hFFFF) begin errors++; $display("FAIL sat_final got %h exp ffff", drop_count_p); end
    checks++; if (fifo_count_p !== 5'd16) begin errors++; $display("FAIL sat_count got %0d exp 16", fifo_count_p); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int j = 0; j < 7; j++) pulse(2, 16'h0A00 + 16'(j), 64'd900 + 64'(j));
    tick();
    tick();
    checks++; if (fifo_count_p !== 5'd7) begin errors++; $display("FAIL t6_pre_count got %0d exp 7", fifo_count_p); end
    ch_valid_p = 4'h1;
    #1;
    reset_n_p = 1'b0;
    #1;
    checks++; if (fifo_count_p !== 5'd0) begin errors++; $display("FAIL t6_count got %0d exp 0", fifo_count_p); end
    checks++; if (fifo_empty_p !== 1'b1) begin errors++; $display("FAIL t6_empty got %b exp 1", fifo_empty_p); end
    checks++; if (fifo_dout_p !== '0) begin errors++; $display("FAIL t6_dout got %h exp 0", fifo_dout_p); end
    checks++; if (ch_current_data_p !== '0) begin errors++; $display("FAIL t6_cur got %h exp 0", ch_current_data_p); end
    ch_valid_p = '0;
    @(negedge clk210_p);
    reset_n_p = 1'b1;
    tick();
    pulse(3, 16'h0B0B, 64'd1000);
    tick();
    tick();
    checks++; if (fifo_count_p !== 5'd1) begin errors++; $display("FAIL t6_after_count got %0d exp 1", fifo_count_p); end
    checks++; if (fifo_dout_p !== ent(64'd1000, 2'd3, 16'h0B0B)) begin errors++; $display("FAIL t6_after_dout got %h exp %h", fifo_dout_p, ent(64'd1000, 2'd3, 16'h0B0B)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_unqualified();
    test_round_robin();
    test_empty_and_simul();
    test_threshold();
    test_full_overrun();
    test_drop_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
